fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Time-shares the single-port 160x120x12 frame buffer between the VGA display read path and the camera capture write path. It sits between the VGA driver (consumes `posX`/`posY`, supplies `pixelIn`), the camera capture logic (pixel write requests) and the frame-buffer RAM. Display reads are scheduled two pixels ahead of the raster and always win. Camera writes are buffered in a small FIFO and drained in cycles that carry no read.

## Interface
- `DW`, 12, pixel width (RGB444)
- `AW`, 15, frame-buffer address width (19200 words)
- `FIFO_AW`, 3, log2 of write-FIFO depth (8 entries)

Ports:
- `clk`  in  1  pixel clock, same as VGA driver (25 MHz)
- `rst`  in  1  reset, asynchronous, active-low
- `posX`  in  9  driver horizontal count, 0..319
- `posY`  in  8  driver vertical count, 0..164
- `pixelOut`  out  DW  pixel for driver `pixelIn`
- `cam_we`  in  1  camera write request, one pixel per asserted cycle
- `cam_addr`  in  AW  camera write address
- `cam_data`  in  DW  camera write data
- `cam_ready`  out  1  FIFO not full; push accepted only when high
- `mem_addr`  out  AW  RAM address, registered
- `mem_we`  out  1  RAM write enable, registered
- `mem_wdata`  out  DW  RAM write data, registered
- `mem_rdata`  in  DW  RAM read data, valid the cycle after address/we are sampled
- `ovf`  out  1  sticky: push attempted while full
- `addr_err`  out  1  sticky: push with `cam_addr` >= 19200

## Operation
- Raster is 320 x 165: active region 160 x 120, with `posX` wrapping at 319 and `posY` wrapping at 164.
- Each cycle, compute the target position two raster steps ahead:
  - `tx = posX+2` if `posX` <= 317; if `posX` = 318, `tx` = 0; if `posX` = 319, `tx` = 1.
  - `ty` increments on wrap; `posY` = 164 wraps to 0.
- Read slot: the target is active (`tx` < 160 and `ty` < 120).
  - Register `mem_addr = ty*160 + tx`, computed as `(ty<<7)+(ty<<5)+tx` in AW bits. Maximum is 19199.
  - `mem_we` = 0.
  - Set the read tag in a 2-stage pipeline.
- Non-read slot with FIFO not empty:
  - Pop the head.
  - Register `mem_addr`/`mem_wdata` from the entry and set `mem_we` = 1.
- Non-read slot with FIFO empty: `mem_we` = 0, and `mem_addr`/`mem_wdata` hold their values.
- `pixelOut` = `mem_rdata` when the stage-2 read tag is set, else 0.
- Write FIFO: 8 entries of {addr, data}.
  - Push when `cam_we` and `cam_ready`.
  - `cam_ready` = not full (combinational from count).
- Push while full: entry is dropped and `ovf` is set. A pop in the same cycle does not rescue it, because `cam_ready` was low.
- Push with `cam_addr` >= 19200: entry is not stored, `addr_err` is set, and `ovf` is unaffected.
- Simultaneous push and pop with FIFO non-full and non-empty: count is unchanged and ordering is preserved.
- `ovf` and `addr_err` clear only on reset.
- Write capacity: 160 slots per active line, plus 320 per blank line. Any camera burst of at most 8 pixels between drain opportunities never overflows.

## Timing
- Reset (`rst` low, asynchronous): all outputs reach these values immediately:
  - `mem_addr` = 0, `mem_we` = 0, `mem_wdata` = 0
  - read tags cleared, so `pixelOut` = 0
  - FIFO empty, so `cam_ready` = 1
  - `ovf` = 0, `addr_err` = 0
- Reset released mid-frame: the first read slot is decided at the first edge and `pixelOut` is valid from the third cycle. Earlier cycles output 0.
- Read latency:
  - Cycle n with `posX`=p: the arbiter decides the slot for p+2.
  - Cycle n+1: `mem_addr` is driven and the RAM samples it at the end of the cycle.
  - Cycle n+2: `posX`=p+2 and `pixelOut` = mem[ty*160+tx].
- Write latency: a push at edge k is visible at the FIFO head at k+1. The earliest `mem_we` assertion is cycle k+2, and only if that cycle is a non-read slot.
- Read-before-write to the same address in one cycle cannot occur, since slots are exclusive.

## Test plan
- Preload RAM with mem[a] = a[11:0], run one full frame: `pixelOut` at (`posX`,`posY`) = (x,y) equals (y*160+x)[11:0] for all active pixels; 0 for every `posX` >= 160 or `posY` >= 120; no `mem_we` during read slots.
- Line-wrap lookahead: `posX` = 318/319 on line 5 issues reads for 960 and 961; `posX` = 318/319 on line 164 issues reads for 0 and 1.
- During active pixels (`posX` < 158, `posY` < 120), push 8 writes: `cam_ready` falls after the 8th; no `mem_we` until `posX` = 158 (target 160); 8 consecutive writes then follow in order with correct addr/data; `cam_ready` rises after the first pop.
- Full FIFO plus a 9th `cam_we`: the entry is dropped, `ovf` = 1 and stays 1 across frames, and the stored 8 entries are written unaltered.
- Push with `cam_addr` = 19200: no write occurs, `addr_err` = 1, FIFO count is unchanged.
- Assert `rst` low mid-write burst: outputs go to their reset values immediately; after release, the FIFO is empty and the next frame's reads are correct from the third cycle.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one frame-buffer port between display reads
// (two pixels ahead of the raster) and FIFO-buffered camera writes.
module fb_port_arbiter #(
    parameter int DW      = 12,
    parameter int AW      = 15,
    parameter int FIFO_AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [8:0]    posX,
    input  logic [7:0]    posY,
    output logic [DW-1:0] pixelOut,
    input  logic          cam_we,
    input  logic [AW-1:0] cam_addr,
    input  logic [DW-1:0] cam_data,
    output logic          cam_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          ovf,
    output logic          addr_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [AW-1:0] FB_WORDS = AW'(19200);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

    logic [8:0]         tx;
    logic [7:0]         ty;
    logic               read_slot;
    logic [AW-1:0]      rd_addr;

    logic [AW-1:0]      fifo_addr [DEPTH];
    logic [DW-1:0]      fifo_data [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               empty;
    logic               addr_ok;
    logic               push;
    logic               pop;
    logic               tag1;
    logic               tag2;

    // Raster position two steps ahead, wrapping at line and frame end.
    always_comb begin
        tx = posX + 9'd2;
        ty = posY;
        if (posX >= 9'd318) begin
            tx = posX - 9'd318;
            ty = (posY >= 8'd164) ? 8'd0 : posY + 8'd1;
        end
    end

    assign read_slot = (tx < 9'd160) && (ty < 8'd120);
    assign rd_addr   = (AW'(ty) << 7) + (AW'(ty) << 5) + AW'(tx);

    assign empty     = (count == '0);
    assign cam_ready = (count != FULL_CNT);
    assign addr_ok   = (cam_addr < FB_WORDS);
    assign push      = cam_we && cam_ready && addr_ok;
    assign pop       = !read_slot && !empty;
    assign pixelOut  = tag2 ? mem_rdata : '0;

    // FIFO payload storage; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cam_addr;
            fifo_data[wr_ptr] <= cam_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Memory port: reads always win, writes drain in free slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (read_slot) begin
            mem_addr  <= rd_addr;
            mem_we    <= 1'b0;
        end else if (!empty) begin
            mem_addr  <= fifo_addr[rd_ptr];
            mem_wdata <= fifo_data[rd_ptr];
            mem_we    <= 1'b1;
        end else begin
            mem_we    <= 1'b0;
        end
    end

    // Read tag pipeline aligning pixelOut with RAM read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag1 <= 1'b0;
            tag2 <= 1'b0;
        end else begin
            tag1 <= read_slot;
            tag2 <= tag1;
        end
    end

    // Sticky error flags for dropped pushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf      <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (cam_we && !cam_ready) ovf <= 1'b1;
            if (cam_we && !addr_ok)   addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed bench with a behavioural frame-buffer RAM
// preloaded with mem[a] = a[11:0].
module tb_fb_port_arbiter;

    logic        clk;
    logic        rst;
    logic [8:0]  posX;
    logic [7:0]  posY;
    logic [11:0] pixelOut;
    logic        cam_we;
    logic [14:0] cam_addr;
    logic [11:0] cam_data;
    logic        cam_ready;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        ovf;
    logic        addr_err;

    logic [11:0] ram [0:19199];
    logic        loaded = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cx;
    int          cy;

    fb_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .posX      (posX),
        .posY      (posY),
        .pixelOut  (pixelOut),
        .cam_we    (cam_we),
        .cam_addr  (cam_addr),
        .cam_data  (cam_data),
        .cam_ready (cam_ready),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .ovf       (ovf),
        .addr_err  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, read data one cycle after address.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 19200; a++) ram[a] <= 12'(a);
            loaded <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int x, input int y);
        if (x < 160 && y < 120) return 32'((y * 160 + x) % 4096);
        return 32'd0;
    endfunction

    task automatic step(input int x, input int y);
        @(posedge clk);
        #1;
        posX = 9'(x);
        posY = 8'(y);
        cx = x;
        cy = y;
    endtask

    task automatic step_next();
        int nx;
        int ny;
        nx = cx + 1;
        ny = cy;
        if (cx == 319) begin
            nx = 0;
            ny = (cy == 164) ? 0 : cy + 1;
        end
        step(nx, ny);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_we"},    32'(mem_we), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_pix"},   32'(pixelOut), 32'd0);
        chk({tag, "_ready"}, 32'(cam_ready), 32'd1);
        chk({tag, "_ovf"},   32'(ovf), 32'd0);
        chk({tag, "_aerr"},  32'(addr_err), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        posX = 9'd310;
        posY = 8'd164;
        cx = 310;
        cy = 164;
        cam_we = 1'b0;
        cam_addr = '0;
        cam_data = '0;
        #3;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b1;

        // Full frame of reads from a settled pipeline.
        for (int n = 0; n < 52810; n++) begin
            step_next();
            chk("frame_pix", 32'(pixelOut), exp_pix(cx, cy));
            chk("frame_we", 32'(mem_we), 32'd0);
            if (cx == 319 && cy == 5) chk("look_960", 32'(mem_addr), 32'd960);
            if (cx == 0 && cy == 6) chk("look_961", 32'(mem_addr), 32'd961);
            if (cx == 319 && cy == 164) chk("look_0", 32'(mem_addr), 32'd0);
            if (cx == 0 && cy == 0) chk("look_1", 32'(mem_addr), 32'd1);
        end

        // Out-of-range push followed by one valid push.
        step(20, 30);
        cam_we = 1'b1;
        cam_addr = 15'd19200;
        cam_data = 12'h123;
        step(21, 30);
        cam_addr = 15'd19150;
        cam_data = 12'h5A5;
        step(22, 30);
        cam_we = 1'b0;
        chk("aerr_set", 32'(addr_err), 32'd1);
        chk("aerr_ovf", 32'(ovf), 32'd0);
        chk("aerr_ready", 32'(cam_ready), 32'd1);
        for (int x = 23; x <= 170; x++) begin
            step(x, 30);
            chk("aerr_we", 32'(mem_we), 32'(x == 159));
            if (x == 159) begin
                chk("aerr_addr", 32'(mem_addr), 32'd19150);
                chk("aerr_data", 32'(mem_wdata), 32'h5A5);
            end
        end

        // Eight pushes fill the FIFO; the ninth is dropped.
        for (int i = 0; i <= 8; i++) begin
            step(100 + i, 10);
            chk("fill_ready", 32'(cam_ready), 32'(i < 8));
            cam_we = 1'b1;
            cam_addr = 15'(19100 + i);
            cam_data = 12'(12'hA00 + i);
        end
        for (int x = 109; x <= 170; x++) begin
            step(x, 10);
            cam_we = 1'b0;
            chk("drain_ovf", 32'(ovf), 32'd1);
            chk("drain_ready", 32'(cam_ready), 32'(x >= 159));
            chk("drain_we", 32'(mem_we), 32'(x >= 159 && x <= 166));
            if (x >= 159 && x <= 166) begin
                chk("drain_addr", 32'(mem_addr), 32'(19100 + x - 159));
                chk("drain_data", 32'(mem_wdata), 32'(12'hA00 + x - 159));
            end
        end

        // Sticky flags survive a frame boundary.
        for (int x = 310; x <= 319; x++) step(x, 164);
        for (int x = 0; x <= 5; x++) step(x, 0);
        chk("sticky_ovf", 32'(ovf), 32'd1);
        chk("sticky_aerr", 32'(addr_err), 32'd1);
        chk("sticky_ready", 32'(cam_ready), 32'd1);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 6; i++) begin
            step(100 + i, 20);
            cam_we = 1'b1;
            cam_addr = 15'(19110 + i);
            cam_data = 12'(12'h300 + i);
        end
        step(106, 20);
        cam_we = 1'b0;
        for (int x = 107; x <= 161; x++) step(x, 20);
        chk("burst_we", 32'(mem_we), 32'd1);
        chk("burst_addr", 32'(mem_addr), 32'd19112);
        #2;
        rst = 1'b0;
        posX = 9'd50;
        posY = 8'd2;
        cx = 50;
        cy = 2;
        #1;
        chk_reset_vals("rst1");
        @(negedge clk);
        rst = 1'b1;
        step(51, 2);
        chk("post_first_pix", 32'(pixelOut), 32'd0);
        for (int n = 0; n < 700; n++) begin
            step_next();
            chk("post_pix", 32'(pixelOut), exp_pix(cx, cy));
            chk("post_we", 32'(mem_we), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
